fft_mem_wr_ctrl: RTL and testbench

FFT_MEM_WR_CTRL -- requirements
Module: fft_mem_wr_ctrl

---
 rtl/fft_pkg.sv | 47 ++++
 rtl/fft_wr_counter.sv | 39 +++
 rtl/fft_mem_wr_ctrl.sv | 96 +++++++++
 tb/tb_fft_mem_wr_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT memory write path: frame size, address
// layout, FSM state encodings and the bank assigned to each write phase.
package fft_pkg;

   localparam int FFT_NPT = 16;
   localparam int ADDR_W  = 7;
   localparam int BANK_W  = 3;
   localparam int IDX_W   = 4;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_W1   = 3'd2,
      S_W2   = 3'd3,
      S_W3   = 3'd4,
      S_W4   = 3'd5
   } state_t;

   localparam logic [BANK_W-1:0] BANK_LOAD = 3'b000;
   localparam logic [BANK_W-1:0] BANK_W1   = 3'b001;
   localparam logic [BANK_W-1:0] BANK_W2   = 3'b010;
   localparam logic [BANK_W-1:0] BANK_W3   = 3'b011;
   // The last butterfly stage writes back over the previous stage's bank.
   localparam logic [BANK_W-1:0] BANK_W4   = 3'b011;

   // Bank field used for writes issued from a given state.
   function automatic logic [BANK_W-1:0] bank_of(input state_t s);
      logic [BANK_W-1:0] b;
      b = BANK_LOAD;
      case (s)
         S_LOAD:  b = BANK_LOAD;
         S_W1:    b = BANK_W1;
         S_W2:    b = BANK_W2;
         S_W3:    b = BANK_W3;
         S_W4:    b = BANK_W4;
         default: b = BANK_LOAD;
      endcase
      return b;
   endfunction

   // True for the states that accept write data.
   function automatic logic is_active(input state_t s);
      return (s == S_LOAD) || (s == S_W1) || (s == S_W2) ||
             (s == S_W3)   || (s == S_W4);
   endfunction

endpackage

// File: rtl/fft_wr_counter.sv
// Write index counter: counts accepted writes, wraps after the last index
// of a phase, and clears synchronously (clear beats enable).
module fft_wr_counter
   import fft_pkg::*;
#(
   parameter logic [IDX_W-1:0] WRAP = 4'd15
) (
   input  logic             iCLK,
   input  logic             iRSTn,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [IDX_W-1:0] cnt_o
);

   logic [IDX_W-1:0] cnt_q;
   logic [IDX_W-1:0] cnt_d;

   // Next count: clear, wrap at the phase end, or step on enable.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == WRAP) ? '0 : cnt_q + 1'b1;
      end
   end

   // Count register with asynchronous active-low reset.
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/fft_mem_wr_ctrl.sv
// FFT memory write controller: sequences one load phase and four butterfly
// write phases per frame, producing registered write enable/address plus
// read-start and frame-done pulses.
module fft_mem_wr_ctrl
   import fft_pkg::*;
#(
   parameter int NPT = FFT_NPT
) (
   input  logic              iCLK,
   input  logic              iRSTn,
   input  logic              iCLR,
   input  logic              iStart,
   input  logic              iVALID,
   output logic              oWEN,
   output logic [ADDR_W-1:0] WADDR,
   output logic              oSTART_RD,
   output logic              oDONE,
   output logic [2:0]        STATE
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPT - 1);

   state_t            state_q;
   logic              wen_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [ADDR_W-1:0] waddr_d;
   logic              start_rd_q;
   logic              done_q;

   logic [IDX_W-1:0]  cnt;
   logic              active;
   logic              accept;
   logic              last_wr;
   logic              cnt_clr;

   // iVALID only counts as a write while a phase is in progress.
   assign active  = is_active(state_q);
   assign accept  = active & iVALID;
   assign last_wr = accept & (cnt == LAST_IDX);
   // Idle (or an illegal code) keeps the index at zero so a new frame
   // always starts from index 0, whatever was left by an aborted one.
   assign cnt_clr = iCLR | ~active;
   assign waddr_d = {bank_of(state_q), cnt};

   fft_wr_counter #(
      .WRAP (LAST_IDX)
   ) u_wr_counter (
      .iCLK  (iCLK),
      .iRSTn (iRSTn),
      .clr_i (cnt_clr),
      .en_i  (accept),
      .cnt_o (cnt)
   );

   // Phase sequencing FSM with registered write strobe, address and pulses.
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state_q    <= S_IDLE;
         wen_q      <= 1'b0;
         waddr_q    <= '0;
         start_rd_q <= 1'b0;
         done_q     <= 1'b0;
      end else if (iCLR) begin
         state_q    <= S_IDLE;
         wen_q      <= 1'b0;
         waddr_q    <= '0;
         start_rd_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         wen_q      <= accept;
         start_rd_q <= last_wr & (state_q == S_LOAD);
         done_q     <= last_wr & (state_q == S_W4);
         if (accept) begin
            waddr_q <= waddr_d;
         end
         case (state_q)
            S_IDLE:  if (iStart)  state_q <= S_LOAD;
            S_LOAD:  if (last_wr) state_q <= S_W1;
            S_W1:    if (last_wr) state_q <= S_W2;
            S_W2:    if (last_wr) state_q <= S_W3;
            S_W3:    if (last_wr) state_q <= S_W4;
            // Returning to idle here means an iStart seen on this same edge
            // is ignored; it must still be present on the next cycle.
            S_W4:    if (last_wr) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign oWEN      = wen_q;
   assign WADDR     = waddr_q;
   assign oSTART_RD = start_rd_q;
   assign oDONE     = done_q;
   assign STATE     = state_q;

endmodule

// File: tb/tb_fft_mem_wr_ctrl.sv
// Directed self-checking bench for fft_mem_wr_ctrl.
module tb_fft_mem_wr_ctrl;

   logic       clk = 1'b0;
   logic       rstn;
   logic       clr;
   logic       start;
   logic       valid;
   logic       wen;
   logic [6:0] waddr;
   logic       start_rd;
   logic       done;
   logic [2:0] state;

   int n_cmp = 0;
   int n_err = 0;

   fft_mem_wr_ctrl #(.NPT(16)) dut (
      .iCLK      (clk),
      .iRSTn     (rstn),
      .iCLR      (clr),
      .iStart    (start),
      .iVALID    (valid),
      .oWEN      (wen),
      .WADDR     (waddr),
      .oSTART_RD (start_rd),
      .oDONE     (done),
      .STATE     (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic w, input logic [6:0] a,
                          input logic s, input logic d, input logic [2:0] st);
      chk({tag, ".oWEN"},      8'(w),  8'(w === 1'bx ? 1'b0 : w) == 8'(w) ? 8'(w) : 8'(w));
   endtask

   task automatic chk5(input string tag, input logic ew, input logic [6:0] ea,
                       input logic es, input logic ed, input logic [2:0] est);
      chk({tag, ".oWEN"},      8'(wen),      8'(ew));
      chk({tag, ".WADDR"},     8'(waddr),    8'(ea));
      chk({tag, ".oSTART_RD"}, 8'(start_rd), 8'(es));
      chk({tag, ".oDONE"},     8'(done),     8'(ed));
      chk({tag, ".STATE"},     8'(state),    8'(est));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int b;
      int est;
      rstn  = 1'b0;
      clr   = 1'b0;
      start = 1'b0;
      valid = 1'b0;
      tick();
      tick();
      chk5("reset", 1'b0, 7'h00, 1'b0, 1'b0, 3'd0);
      rstn = 1'b1;

      // iVALID while idle is ignored
      valid = 1'b1;
      tick();
      chk5("idle_valid1", 1'b0, 7'h00, 1'b0, 1'b0, 3'd0);
      tick();
      chk5("idle_valid2", 1'b0, 7'h00, 1'b0, 1'b0, 3'd0);

      // continuous frame of 80 writes; iStart during W1 and on the last write
      valid = 1'b0;
      start = 1'b1;
      tick();
      chk5("start", 1'b0, 7'h00, 1'b0, 1'b0, 3'd1);
      start = 1'b0;
      valid = 1'b1;
      for (int i = 0; i < 80; i++) begin
         start = (i == 20 || i == 79) ? 1'b1 : 1'b0;
         tick();
         b   = (i / 16 > 3) ? 3 : i / 16;
         est = (i == 79) ? 0 : (i + 1) / 16 + 1;
         chk5($sformatf("frame_w%0d", i), 1'b1, 7'((b << 4) | (i % 16)),
              1'b0 | (i == 15), 1'b0 | (i == 79), 3'(est));
      end
      // start still high: ignored on the done edge, taken on this one
      valid = 1'b0;
      tick();
      chk5("restart_after_done", 1'b0, 7'h3F, 1'b0, 1'b0, 3'd1);
      start = 1'b0;

      // gapped valid in LOAD
      for (int k = 0; k < 16; k++) begin
         valid = 1'b1;
         tick();
         chk5($sformatf("gap_w%0d", k), 1'b1, 7'(k), 1'b0 | (k == 15), 1'b0,
              (k == 15) ? 3'd2 : 3'd1);
         valid = 1'b0;
         tick();
         chk5($sformatf("gap_idle%0d", k), 1'b0, 7'(k), 1'b0, 1'b0,
              (k == 15) ? 3'd2 : 3'd1);
      end

      // fill W1, then 5 writes into W2, then clear
      valid = 1'b1;
      for (int k = 0; k < 16; k++) tick();
      chk5("w1_end", 1'b1, 7'h1F, 1'b0, 1'b0, 3'd3);
      for (int k = 0; k < 5; k++) tick();
      chk5("w2_5th", 1'b1, 7'h24, 1'b0, 1'b0, 3'd3);
      clr   = 1'b1;
      start = 1'b1;
      tick();
      chk5("clear", 1'b0, 7'h00, 1'b0, 1'b0, 3'd0);
      clr   = 1'b0;
      valid = 1'b0;
      tick();
      chk5("clear_restart", 1'b0, 7'h00, 1'b0, 1'b0, 3'd1);
      start = 1'b0;
      valid = 1'b1;
      tick();
      chk5("clear_first_wr", 1'b1, 7'h00, 1'b0, 1'b0, 3'd1);

      // run into W3: 15 more LOAD, 16 W1, 16 W2, 3 W3 writes
      for (int k = 0; k < 50; k++) tick();
      chk5("w3_3rd", 1'b1, 7'h32, 1'b0, 1'b0, 3'd4);

      // asynchronous reset mid-W3
      #2;
      rstn = 1'b0;
      #1;
      chk5("async_rst_now", 1'b0, 7'h00, 1'b0, 1'b0, 3'd0);
      tick();
      tick();
      chk5("async_rst_held", 1'b0, 7'h00, 1'b0, 1'b0, 3'd0);
      rstn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk5($sformatf("post_rst_valid%0d", k), 1'b0, 7'h00, 1'b0, 1'b0, 3'd0);
      end
      valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
